inst_prefetch: RTL and testbench
================================

INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, instruction/data width.
REQ-002 The block SHALL have parameter ADDRSIZE, default 32, address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, at least 2).
REQ-004 The block SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 The block SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 The block SHALL have port rst  in  1  synchronous, active-low reset.
REQ-007 The block SHALL have port mem_read_i  out  1  instruction-memory read request.
REQ-008 The block SHALL have port mem_addr_i  out  ADDRSIZE  instruction-memory address.
REQ-009 The block SHALL have port inst_in  in  WIDTH  instruction-memory read data, valid when imem_done=1.
REQ-010 The block SHALL have port imem_done  in  1  instruction-memory completion strobe.
REQ-011 The block SHALL have port inst_valid  out  1  queue head holds an instruction.
REQ-012 The block SHALL have port inst_ready  in  1  CPU accepts the head this cycle.
REQ-013 The block SHALL have port inst_data  out  WIDTH  head instruction.
REQ-014 The block SHALL have port inst_pc  out  ADDRSIZE  address of the head instruction.
REQ-015 The block SHALL have port redirect  in  1  flush and restart fetch (branch/jump taken).
REQ-016 The block SHALL have port redirect_pc  in  ADDRSIZE  restart address; bits [1:0] ignored and treated as 0.

Function
REQ-017 fetch_pc SHALL hold the next address to request; it advances by 4 (modulo 2^ADDRSIZE, wrapping silently) on each accepted, non-discarded response.
REQ-018 Fetch FSM SHALL have states IDLE (no request), BUSY (request outstanding), DROP (outstanding request whose data is discarded).
REQ-019 IDLE->BUSY SHALL occur when count + 0 < DEPTH and no redirect; mem_read_i=1 and mem_addr_i=fetch_pc from the BUSY cycle on.
REQ-020 mem_read_i and mem_addr_i SHALL stay stable in BUSY/DROP up to and including the cycle imem_done=1.
REQ-021 BUSY with imem_done=1 and no redirect SHALL push {fetch_pc, inst_in} and stay BUSY with the incremented address if a free slot remains after the push (accounting for a same-cycle pop), else go IDLE.
REQ-022 inst_valid SHALL equal (count != 0), driven from registers; inst_data/inst_pc SHALL present the head entry.
REQ-023 A pop SHALL occur when inst_valid and inst_ready; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-024 A push SHALL never occur when count == DEPTH; requests are only issued when a slot is free, so no overflow is possible.
REQ-025 redirect SHALL take priority over push and pop: queue count cleared to 0 next cycle, fetch_pc <= {redirect_pc[ADDRSIZE-1:2], 2'b00}.
REQ-026 redirect in BUSY without imem_done SHALL go to DROP; DROP keeps request stable, discards data on imem_done, then goes IDLE.
REQ-027 redirect in BUSY with imem_done in the same cycle SHALL discard that data and go IDLE.
REQ-028 redirect in DROP SHALL update fetch_pc only; state stays DROP.
REQ-029 inst_ready while inst_valid=0 SHALL have no effect.
REQ-030 First request after a redirect from IDLE SHALL be issued in the cycle after redirect (one-cycle bubble).

Reset
REQ-031 While rst=0 at a rising edge: state=IDLE, count=0, read/write pointers=0, fetch_pc=RESET_PC.
REQ-032 Reset outputs SHALL be mem_read_i=0, mem_addr_i=RESET_PC, inst_valid=0; inst_data/inst_pc are don't-care.
REQ-033 Reset mid-request SHALL abandon the outstanding request; a later imem_done SHALL be ignored in IDLE.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding (IDLE/BUSY/DROP) and the PC increment constant 4.
REQ-035 Queue SHALL be a sub-module prefetch_fifo (sync FIFO, DEPTH x (ADDRSIZE+WIDTH), push/pop/flush, count output).

Verification
REQ-036 Reset then memory done latency 1, inst_ready=1: CPU receives pc 0x0,0x4,0x8 in order with matching memory words.
REQ-037 inst_ready=0, latency 1: exactly 4 pushes, then mem_read_i=0 and inst_valid stays 1 with pc 0x0; raising inst_ready resumes at 0x10.
REQ-038 Latency 3, redirect to 0x103 in second BUSY cycle: DROP entered, late data discarded, next request addr 0x100, first delivered pc 0x100.
REQ-039 redirect coincident with imem_done and with inst_ready pop: queue empty next cycle, no entry from old stream ever delivered.
REQ-040 RESET_PC=0xFFFFFFF8, latency 1: delivered pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x0 (wrap).
REQ-041 rst=0 asserted while BUSY, memory completes two cycles later: no push, inst_valid=0, next request addr RESET_PC.

Source files
------------

// File: rtl/inst_prefetch_pkg.sv
// Shared definitions for the instruction prefetcher: fetch FSM encoding and PC step.
package inst_prefetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_BUSY = 2'd1;
  localparam fetch_state_t ST_DROP = 2'd2;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/inst_prefetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries between the fetch engine and the CPU.
module prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush && (count != CW'(DEPTH));
  assign do_pop  = pop && !flush && (count != '0);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the queue ahead of any push or pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage needs no reset since occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: issues sequential fetches into a small queue and flushes on redirect.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int                    WIDTH    = 32,
  parameter int                    ADDRSIZE = 32,
  parameter int                    DEPTH    = 4,
  parameter logic [ADDRSIZE-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_read_i,
  output logic [ADDRSIZE-1:0] mem_addr_i,
  input  logic [WIDTH-1:0]    inst_in,
  input  logic                imem_done,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [WIDTH-1:0]    inst_data,
  output logic [ADDRSIZE-1:0] inst_pc,
  input  logic                redirect,
  input  logic [ADDRSIZE-1:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t                  state;
  logic [ADDRSIZE-1:0]           fetch_pc;
  logic [ADDRSIZE-1:0]           req_addr;
  logic [ADDRSIZE-1:0]           redirect_base;
  logic [ADDRSIZE-1:0]           next_pc;
  logic [CW-1:0]                 count;
  logic                          push;
  logic                          pop;
  logic                          slot_after_push;
  logic [ADDRSIZE+WIDTH-1:0]     head;
  logic                          unused_pc_bits;

  assign redirect_base   = {redirect_pc[ADDRSIZE-1:2], 2'b00};
  assign unused_pc_bits  = &{1'b0, redirect_pc[1:0]};
  assign next_pc         = fetch_pc + ADDRSIZE'(PC_INC);

  assign inst_valid      = (count != '0);
  assign pop             = inst_valid && inst_ready && !redirect;
  assign push            = (state == ST_BUSY) && imem_done && !redirect;
  assign slot_after_push = pop || (count < CW'(DEPTH - 1));

  assign mem_read_i      = (state != ST_IDLE);
  assign mem_addr_i      = req_addr;
  assign {inst_pc, inst_data} = head;

  // Fetch FSM; req_addr is only reloaded when a new request starts so the bus stays stable in BUSY/DROP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_base;
          end else if (count < CW'(DEPTH)) begin
            state    <= ST_BUSY;
            req_addr <= fetch_pc;
          end
        end
        ST_BUSY: begin
          if (redirect) begin
            fetch_pc <= redirect_base;
            state    <= imem_done ? ST_IDLE : ST_DROP;
          end else if (imem_done) begin
            fetch_pc <= next_pc;
            if (slot_after_push) begin
              req_addr <= next_pc;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (redirect) fetch_pc <= redirect_base;
          if (imem_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  prefetch_fifo #(
    .WIDTH (ADDRSIZE + WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({fetch_pc, inst_in}),
    .rdata (head),
    .count (count)
  );

endmodule

// File: tb/tb_inst_prefetch.sv
// Scoreboard bench for inst_prefetch: directed segments push expected deliveries, monitors compare.
module tb_inst_prefetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read_i;
  logic [31:0] mem_addr_i;
  logic [31:0] inst_in = '0;
  logic        imem_done = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        rst_w = 1'b0;
  logic        mem_read_w;
  logic [31:0] mem_addr_w;
  logic [31:0] inst_in_w = '0;
  logic        done_w = 1'b0;
  logic        inst_valid_w;
  logic        ready_w = 1'b0;
  logic [31:0] inst_data_w;
  logic [31:0] inst_pc_w;

  int   n_checks = 0;
  int   n_pass = 0;
  int   delivered = 0;
  int   delivered_w = 0;
  int   done_count = 0;
  int   mem_lat = 1;
  bit   mem_auto = 1'b1;
  exp_t exp_q[$];
  exp_t exp_w_q[$];

  inst_prefetch #(.WIDTH(32), .ADDRSIZE(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_read_i(mem_read_i), .mem_addr_i(mem_addr_i),
    .inst_in(inst_in), .imem_done(imem_done), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  inst_prefetch #(.WIDTH(32), .ADDRSIZE(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst_w), .mem_read_i(mem_read_w), .mem_addr_i(mem_addr_w),
    .inst_in(inst_in_w), .imem_done(done_w), .inst_valid(inst_valid_w),
    .inst_ready(ready_w), .inst_data(inst_data_w), .inst_pc(inst_pc_w),
    .redirect(1'b0), .redirect_pc(32'h0)
  );

  // Free-running clock.
  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  task automatic expectEntry(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    done_count = 0;
    delivered  = 0;
  endtask

  task automatic waitBusy(input string name);
    for (int i = 0; i < 20 && !mem_read_i; i++) tick(1);
    checkOutput(name, mem_read_i, 1'b1);
  endtask

  task automatic waitDeliveries(input int target);
    for (int i = 0; i < 60 && delivered < target; i++) tick(1);
    inst_ready = 1'b0;
    checkOutput("delivery_count", delivered, target);
  endtask

  // Instruction memory for the main instance: answers after mem_lat cycles of a held request.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_auto) begin
        wait_cnt = 0;
      end else if (mem_read_i) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          imem_done = 1'b1;
          inst_in   = mem_word(mem_addr_i);
          wait_cnt  = 0;
          done_count++;
        end else begin
          imem_done = 1'b0;
        end
      end else begin
        imem_done = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // Single-cycle instruction memory for the wrap instance.
  initial forever begin
    @(posedge clk);
    #1;
    done_w    = mem_read_w;
    inst_in_w = mem_word(mem_addr_w);
  end

  // Monitor for the main instance: every accepted head is checked against the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst && inst_valid && inst_ready && !redirect) begin
      delivered++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_delivery: got pc 0x%0h, expected no delivery", inst_pc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("head_pc", inst_pc, e.pc);
        checkOutput("head_data", inst_data, e.data);
      end
    end
  end

  // Monitor for the wrap instance.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_w && inst_valid_w && ready_w) begin
      delivered_w++;
      if (exp_w_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_wrap_delivery: got pc 0x%0h, expected no delivery", inst_pc_w);
      end else begin
        e = exp_w_q.pop_front();
        checkOutput("wrap_pc", inst_pc_w, e.pc);
        checkOutput("wrap_data", inst_data_w, e.data);
      end
    end
  end

  // Directed segments.
  initial begin
    int n_done;

    // Reset state and simple in-order stream at latency 1.
    tick(2);
    checkOutput("rst_mem_read", mem_read_i, 1'b0);
    checkOutput("rst_mem_addr", mem_addr_i, 32'h0);
    checkOutput("rst_inst_valid", inst_valid, 1'b0);
    rst = 1'b1;
    mem_lat = 1;
    expectEntry(32'h0);
    expectEntry(32'h4);
    expectEntry(32'h8);
    inst_ready = 1'b1;
    waitDeliveries(3);

    // Queue fills with the CPU stalled, then resumes at 0x10.
    doReset();
    tick(10);
    checkOutput("full_push_count", done_count, 4);
    checkOutput("full_mem_read", mem_read_i, 1'b0);
    checkOutput("full_inst_valid", inst_valid, 1'b1);
    checkOutput("full_head_pc", inst_pc, 32'h0);
    checkOutput("full_head_data", inst_data, mem_word(32'h0));
    for (int a = 0; a <= 16; a += 4) expectEntry(a);
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick(2);
    checkOutput("resume_mem_read", mem_read_i, 1'b1);
    checkOutput("resume_mem_addr", mem_addr_i, 32'h10);
    waitDeliveries(5);

    // Redirect during a slow request: DROP holds the old request, then restart at 0x100.
    mem_lat = 3;
    doReset();
    expectEntry(32'h100);
    expectEntry(32'h104);
    applyStimulus(1'b1, 1'b0, 32'h0);
    waitBusy("drop_busy_start");
    tick(1);
    applyStimulus(1'b1, 1'b1, 32'h103);
    tick(1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("drop_mem_read", mem_read_i, 1'b1);
    checkOutput("drop_mem_addr", mem_addr_i, 32'h0);
    tick(1);
    checkOutput("drop_then_idle", mem_read_i, 1'b0);
    tick(1);
    checkOutput("drop_restart_read", mem_read_i, 1'b1);
    checkOutput("drop_restart_addr", mem_addr_i, 32'h100);
    waitDeliveries(2);

    // Redirect coinciding with a memory response and a CPU pop.
    mem_lat = 2;
    doReset();
    n_done = 0;
    for (int i = 0; i < 20 && n_done < 2; i++) begin
      @(posedge clk);
      #2;
      if (imem_done) n_done++;
    end
    checkOutput("coinc_done_seen", n_done, 2);
    checkOutput("coinc_pre_valid", inst_valid, 1'b1);
    expectEntry(32'h200);
    applyStimulus(1'b1, 1'b1, 32'h200);
    tick(1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("coinc_flushed", inst_valid, 1'b0);
    checkOutput("coinc_idle", mem_read_i, 1'b0);
    tick(1);
    checkOutput("coinc_restart_addr", mem_addr_i, 32'h200);
    waitDeliveries(1);

    // Reset while a request is outstanding; the late response must be ignored.
    mem_lat = 1;
    doReset();
    mem_auto  = 1'b0;
    imem_done = 1'b0;
    waitBusy("rstmid_busy");
    rst = 1'b0;
    tick(1);
    checkOutput("rstmid_mem_read", mem_read_i, 1'b0);
    checkOutput("rstmid_valid", inst_valid, 1'b0);
    tick(1);
    rst       = 1'b1;
    imem_done = 1'b1;
    inst_in   = 32'hDEAD_BEEF;
    tick(1);
    imem_done = 1'b0;
    checkOutput("rstmid_no_push", inst_valid, 1'b0);
    checkOutput("rstmid_req", mem_read_i, 1'b1);
    checkOutput("rstmid_req_addr", mem_addr_i, 32'h0);
    tick(1);
    checkOutput("rstmid_still_empty", inst_valid, 1'b0);

    // Address wrap on the second instance.
    checkOutput("wrap_rst_addr", mem_addr_w, 32'hFFFF_FFF8);
    checkOutput("wrap_rst_valid", inst_valid_w, 1'b0);
    exp_w_q.push_back({32'hFFFF_FFF8, mem_word(32'hFFFF_FFF8)});
    exp_w_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
    exp_w_q.push_back({32'h0000_0000, mem_word(32'h0000_0000)});
    ready_w = 1'b1;
    rst_w   = 1'b1;
    for (int i = 0; i < 60 && delivered_w < 3; i++) tick(1);
    ready_w = 1'b0;
    checkOutput("wrap_delivery_count", delivered_w, 3);

    tick(2);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    checkOutput("wrap_scoreboard_drained", exp_w_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
